// File: rtl/command_word_sequencer_if.sv
// -----------------------------------------------------------------------------
// command_word_sequencer_if
// Write-side bus between the 8259A read/write bus interface and the command
// word sequencer.
//   master : bus interface side; drives wrStrobe, A0, DBus and observes
//            cmdData, the seven command-word strobes, initDone and cmdError.
//   slave  : sequencer side; mirror image of master.
// Signals:
//   wrStrobe  one-cycle write pulse (CS/WR already qualified)
//   A0        address bit of the write
//   DBus[7:0] write data, valid while wrStrobe is high
//   cmdData   registered copy of the last accepted write byte
//   ICW1flag..ICW4flag, OCW1flag..OCW3flag  one-cycle command-word strobes
//   initDone  high while the initialization sequence is complete
//   cmdError  one-cycle pulse on an ignored write
// -----------------------------------------------------------------------------
interface command_word_sequencer_if;
    logic       wrStrobe;
    logic       A0;
    logic [7:0] DBus;
    logic [7:0] cmdData;
    logic       ICW1flag;
    logic       ICW2flag;
    logic       ICW3flag;
    logic       ICW4flag;
    logic       OCW1flag;
    logic       OCW2flag;
    logic       OCW3flag;
    logic       initDone;
    logic       cmdError;

    modport master (
        output wrStrobe, A0, DBus,
        input  cmdData, ICW1flag, ICW2flag, ICW3flag, ICW4flag,
               OCW1flag, OCW2flag, OCW3flag, initDone, cmdError
    );

    modport slave (
        input  wrStrobe, A0, DBus,
        output cmdData, ICW1flag, ICW2flag, ICW3flag, ICW4flag,
               OCW1flag, OCW2flag, OCW3flag, initDone, cmdError
    );
endinterface

// File: rtl/command_word_sequencer.sv
// -----------------------------------------------------------------------------
// command_word_sequencer
// Classifies each CPU write to the 8259A into exactly one command-word strobe
// (ICW1..ICW4, OCW1..OCW3) and enforces the ICW1 -> ICW2 -> [ICW3] -> [ICW4]
// initialization order. Writes that are illegal in the current state are
// dropped and reported with a one-cycle cmdError pulse.
// Ports:
//   clk    system clock, rising-edge active
//   reset  synchronous active-high reset (wins over a same-cycle write)
//   bus    slave modport of command_word_sequencer_if (write inputs,
//          registered cmdData, strobes, initDone, cmdError)
// All outputs are registered: a write sampled at edge N is visible in N+1.
// -----------------------------------------------------------------------------
module command_word_sequencer (
    input  logic                          clk,
    input  logic                          reset,
    command_word_sequencer_if.slave       bus
);

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    // One-hot strobe vector bit positions.
    localparam int F_ICW1 = 0;
    localparam int F_ICW2 = 1;
    localparam int F_ICW3 = 2;
    localparam int F_ICW4 = 3;
    localparam int F_OCW1 = 4;
    localparam int F_OCW2 = 5;
    localparam int F_OCW3 = 6;

    state_t     state_r;
    state_t     state_next_s;
    logic       sngl_r;
    logic       ic4_r;
    logic [7:0] cmd_data_r;
    logic [6:0] flags_r;
    logic [6:0] flags_next_s;
    logic       cmd_error_r;
    logic       cmd_error_next_s;
    logic       init_done_r;
    logic       load_icw1_s;
    logic       accept_s;

    // Next-state and strobe decode; first matching classification wins.
    always_comb begin
        state_next_s     = state_r;
        flags_next_s     = 7'b000_0000;
        cmd_error_next_s = 1'b0;
        load_icw1_s      = 1'b0;
        accept_s         = 1'b0;
        if (bus.wrStrobe) begin
            if ((bus.A0 == 1'b0) && bus.DBus[4]) begin
                // ICW1 restarts initialization from any state, including READY.
                flags_next_s[F_ICW1] = 1'b1;
                state_next_s         = WAIT_ICW2;
                load_icw1_s          = 1'b1;
                accept_s             = 1'b1;
            end else if (bus.A0 == 1'b1) begin
                case (state_r)
                    WAIT_ICW2: begin
                        flags_next_s[F_ICW2] = 1'b1;
                        accept_s             = 1'b1;
                        if (!sngl_r) begin
                            state_next_s = WAIT_ICW3;
                        end else if (ic4_r) begin
                            state_next_s = WAIT_ICW4;
                        end else begin
                            state_next_s = READY;
                        end
                    end
                    WAIT_ICW3: begin
                        flags_next_s[F_ICW3] = 1'b1;
                        accept_s             = 1'b1;
                        state_next_s         = ic4_r ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: begin
                        flags_next_s[F_ICW4] = 1'b1;
                        accept_s             = 1'b1;
                        state_next_s         = READY;
                    end
                    READY: begin
                        flags_next_s[F_OCW1] = 1'b1;
                        accept_s             = 1'b1;
                    end
                    default: begin
                        // UNINIT (or an unreachable encoding): nothing to program yet.
                        cmd_error_next_s = 1'b1;
                    end
                endcase
            end else if (state_r == READY) begin
                // A0=0 with D4=0: D3 selects OCW3 over OCW2.
                if (bus.DBus[3]) begin
                    flags_next_s[F_OCW3] = 1'b1;
                end else begin
                    flags_next_s[F_OCW2] = 1'b1;
                end
                accept_s = 1'b1;
            end else begin
                cmd_error_next_s = 1'b1;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // State, ICW1 option latches, data copy and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= UNINIT;
            sngl_r      <= 1'b0;
            ic4_r       <= 1'b0;
            cmd_data_r  <= 8'h00;
            flags_r     <= 7'b000_0000;
            cmd_error_r <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            flags_r     <= flags_next_s;
            cmd_error_r <= cmd_error_next_s;
            // initDone tracks the state register, so it changes with the strobe.
            init_done_r <= (state_next_s == READY);
            if (load_icw1_s) begin
                sngl_r <= bus.DBus[1];
                ic4_r  <= bus.DBus[0];
            end
            if (accept_s) begin
                cmd_data_r <= bus.DBus;
            end
        end
    end

    assign bus.cmdData  = cmd_data_r;
    assign bus.ICW1flag = flags_r[F_ICW1];
    assign bus.ICW2flag = flags_r[F_ICW2];
    assign bus.ICW3flag = flags_r[F_ICW3];
    assign bus.ICW4flag = flags_r[F_ICW4];
    assign bus.OCW1flag = flags_r[F_OCW1];
    assign bus.OCW2flag = flags_r[F_OCW2];
    assign bus.OCW3flag = flags_r[F_OCW3];
    assign bus.initDone = init_done_r;
    assign bus.cmdError = cmd_error_r;

endmodule

// File: tb/tb_command_word_sequencer.sv
// -----------------------------------------------------------------------------
// tb_command_word_sequencer
// Directed bench for command_word_sequencer. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge that processed
// the step. Strobe vector encoding used in expectations:
//   bit0 ICW1, bit1 ICW2, bit2 ICW3, bit3 ICW4, bit4 OCW1, bit5 OCW2, bit6 OCW3
// -----------------------------------------------------------------------------
module tb_command_word_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    command_word_sequencer_if bus ();

    command_word_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] N   = 7'h00;
    localparam logic [6:0] I1  = 7'h01;
    localparam logic [6:0] I2  = 7'h02;
    localparam logic [6:0] I3  = 7'h04;
    localparam logic [6:0] I4  = 7'h08;
    localparam logic [6:0] O1  = 7'h10;
    localparam logic [6:0] O2  = 7'h20;
    localparam logic [6:0] O3  = 7'h40;

    // Apply one cycle of stimulus and wait until just after the rising edge.
    task automatic step(input logic rst, input logic strb, input logic a0, input logic [7:0] d);
        @(negedge clk);
        reset        = rst;
        bus.wrStrobe = strb;
        bus.A0       = a0;
        bus.DBus     = d;
        @(posedge clk);
        #1;
    endtask

    // Compare all observable outputs against hand-computed values.
    task automatic check(input string tag, input logic [6:0] exp_flags, input logic [7:0] exp_data,
                         input logic exp_init, input logic exp_err);
        logic [6:0] obs_flags;
        obs_flags = {bus.OCW3flag, bus.OCW2flag, bus.OCW1flag, bus.ICW4flag,
                     bus.ICW3flag, bus.ICW2flag, bus.ICW1flag};
        checks++;
        assert (obs_flags === exp_flags) else begin
            errors++;
            $error("FAIL %s flags observed=%b expected=%b", tag, obs_flags, exp_flags);
        end
        checks++;
        assert (bus.cmdData === exp_data) else begin
            errors++;
            $error("FAIL %s cmdData observed=%h expected=%h", tag, bus.cmdData, exp_data);
        end
        checks++;
        assert (bus.initDone === exp_init) else begin
            errors++;
            $error("FAIL %s initDone observed=%b expected=%b", tag, bus.initDone, exp_init);
        end
        checks++;
        assert (bus.cmdError === exp_err) else begin
            errors++;
            $error("FAIL %s cmdError observed=%b expected=%b", tag, bus.cmdError, exp_err);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.wrStrobe = 1'b0;
        bus.A0       = 1'b0;
        bus.DBus     = 8'h00;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 8'h00); check("reset0",      N,  8'h00, 1'b0, 1'b0);

        // Full sequence with ICW3 and ICW4, back-to-back
        step(1'b0, 1'b1, 1'b0, 8'h11); check("seq_icw1",    I1, 8'h11, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hCA); check("seq_icw2",    I2, 8'hCA, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h1E); check("seq_icw3",    I3, 8'h1E, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h12); check("seq_icw4",    I4, 8'h12, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00); check("seq_idle",    N,  8'h12, 1'b1, 1'b0);

        // Single mode without ICW4: ICW3/ICW4 skipped
        step(1'b0, 1'b1, 1'b0, 8'h1A); check("sngl_icw1",   I1, 8'h1A, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h20); check("sngl_icw2",   I2, 8'h20, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00); check("sngl_idle",   N,  8'h20, 1'b1, 1'b0);

        // Operation command words in READY
        step(1'b0, 1'b1, 1'b1, 8'h6A); check("ocw1",        O1, 8'h6A, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hC4); check("ocw2",        O2, 8'hC4, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h0B); check("ocw3_0b",     O3, 8'h0B, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h0A); check("ocw3_0a",     O3, 8'h0A, 1'b1, 1'b0);

        // Ignored writes in UNINIT
        step(1'b1, 1'b0, 1'b0, 8'h00); check("reset1",      N,  8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hFF); check("uninit_a1",   N,  8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h0B); check("uninit_a0",   N,  8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00); check("uninit_idle", N,  8'h00, 1'b0, 1'b0);

        // Ignored A0=0 write in WAIT_ICW2 keeps the state
        step(1'b0, 1'b1, 1'b0, 8'h10); check("w2_icw1",     I1, 8'h10, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h0B); check("w2_ignored",  N,  8'h10, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h55); check("w2_icw2",     I2, 8'h55, 1'b0, 1'b0);

        // Reset together with a write in WAIT_ICW3: write dropped
        step(1'b1, 1'b1, 1'b1, 8'h77); check("rst_w3",      N,  8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h33); check("rst_w3_after",N,  8'h00, 1'b0, 1'b1);

        // ICW1 from READY restarts the sequence
        step(1'b0, 1'b1, 1'b0, 8'h12); check("re_icw1",     I1, 8'h12, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h40); check("re_icw2",     I2, 8'h40, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h13); check("ready_icw1",  I1, 8'h13, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h08); check("ready_icw2",  I2, 8'h08, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h09); check("ready_icw4",  I4, 8'h09, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hEE); check("final_idle",  N,  8'h09, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
